// File: rtl/bin_to_seven_segment_if.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_seven_segment_if
//  Description : Bundles the value input and the display outputs of the
//                seven-segment decoder. The master drives the value; the
//                slave (the decoder) drives the LED mirror and segment pins.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bin_to_seven_segment_if;
    logic [3:0] bin;
    logic [3:0] led_ind;
    logic [6:0] seg;

    modport master (
        output bin,
        input  led_ind,
        input  seg
    );

    modport slave (
        input  bin,
        output led_ind,
        output seg
    );
endinterface
`default_nettype wire

// File: rtl/bin_to_seven_segment.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_seven_segment
//  Description : Registered 4-bit binary to hexadecimal seven-segment decoder
//                with a registered binary LED mirror. Segment order on seg is
//                a..g at bits 0..6; SEG_ACTIVE_LOW selects pin polarity.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_seven_segment #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    bin_to_seven_segment_if.slave   bus
);

    // All segments dark in the selected polarity.
    localparam logic [6:0] c_seg_dark = SEG_ACTIVE_LOW ? 7'b111_1111 : 7'b000_0000;

    logic [6:0] w_seg_lit;
    logic [6:0] seg_d;
    logic [3:0] led_d;
    logic [6:0] seg_q;
    logic [3:0] led_q;

    // Hex glyph lookup, active-high, bits g..a; every code has a glyph.
    always_comb begin
        w_seg_lit = 7'b000_0000;
        case (bus.bin)
            4'h0: w_seg_lit = 7'b011_1111;
            4'h1: w_seg_lit = 7'b000_0110;
            4'h2: w_seg_lit = 7'b101_1011;
            4'h3: w_seg_lit = 7'b100_1111;
            4'h4: w_seg_lit = 7'b110_0110;
            4'h5: w_seg_lit = 7'b110_1101;
            4'h6: w_seg_lit = 7'b111_1101;
            4'h7: w_seg_lit = 7'b000_0111;
            4'h8: w_seg_lit = 7'b111_1111;
            4'h9: w_seg_lit = 7'b110_1111;
            4'hA: w_seg_lit = 7'b111_0111;
            4'hB: w_seg_lit = 7'b111_1100;
            4'hC: w_seg_lit = 7'b011_1001;
            4'hD: w_seg_lit = 7'b101_1110;
            4'hE: w_seg_lit = 7'b111_1001;
            4'hF: w_seg_lit = 7'b111_0001;
        endcase
    end

    // Apply pin polarity and form the LED mirror for the next edge.
    always_comb begin
        seg_d = SEG_ACTIVE_LOW ? ~w_seg_lit : w_seg_lit;
        led_d = bus.bin;
    end

    // Output registers keep the pins glitch-free; reset blanks the display.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q <= c_seg_dark;
            led_q <= 4'b0000;
        end else begin
            seg_q <= seg_d;
            led_q <= led_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.led_ind = led_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_seven_segment.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin_to_seven_segment
//  Description : Self-checking bench for bin_to_seven_segment. Two instances
//                (active-low and active-high pins) share clock, reset and
//                value; a behavioural glyph model predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_seven_segment;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [6:0] glyph [16];

    bin_to_seven_segment_if if_al ();
    bin_to_seven_segment_if if_ah ();

    bin_to_seven_segment #(.SEG_ACTIVE_LOW(1'b1)) u_dut_al (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_al.slave)
    );

    bin_to_seven_segment #(.SEG_ACTIVE_LOW(1'b0)) u_dut_ah (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_ah.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected pin value from the display rules: lit segments of the glyph,
    // inverted for active-low pins, all dark while in reset.
    function automatic logic [6:0] model_seg(input logic [3:0] v, input bit in_rst, input bit act_low);
        logic [6:0] lit;
        lit = in_rst ? 7'b000_0000 : glyph[v];
        return act_low ? ~lit : lit;
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Compare both instances against the model for the inputs of the last edge.
    task automatic check_all(input string tag, input logic [3:0] v, input bit r_n);
        check({tag, ".seg_al"}, if_al.seg, model_seg(v, !r_n, 1'b1));
        check({tag, ".seg_ah"}, if_ah.seg, model_seg(v, !r_n, 1'b0));
        check({tag, ".led_al"}, {3'b000, if_al.led_ind}, r_n ? {3'b000, v} : 7'b000_0000);
        check({tag, ".led_ah"}, {3'b000, if_ah.led_ind}, r_n ? {3'b000, v} : 7'b000_0000);
    endtask

    // Apply inputs away from the active edge, then sample just after it.
    task automatic step(input logic [3:0] v, input bit r_n);
        @(negedge clk);
        if_al.bin = v;
        if_ah.bin = v;
        rst_n     = r_n;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] v;
        bit         r;
        tests = 0;
        fails = 0;

        // Glyph shapes (segments g..a lit), as drawn on a hex display.
        glyph[0]  = 7'b011_1111; glyph[1]  = 7'b000_0110;
        glyph[2]  = 7'b101_1011; glyph[3]  = 7'b100_1111;
        glyph[4]  = 7'b110_0110; glyph[5]  = 7'b110_1101;
        glyph[6]  = 7'b111_1101; glyph[7]  = 7'b000_0111;
        glyph[8]  = 7'b111_1111; glyph[9]  = 7'b110_1111;
        glyph[10] = 7'b111_0111; glyph[11] = 7'b111_1100;
        glyph[12] = 7'b011_1001; glyph[13] = 7'b101_1110;
        glyph[14] = 7'b111_1001; glyph[15] = 7'b111_0001;

        rst_n     = 1'b0;
        if_al.bin = 4'hA;
        if_ah.bin = 4'hA;

        // Reset held for two edges with a nonzero value waiting.
        step(4'hA, 1'b0);
        step(4'hA, 1'b0);
        check("rst.seg_al_dark", if_al.seg, 7'b111_1111);
        check("rst.seg_ah_dark", if_ah.seg, 7'b000_0000);
        check("rst.led", {3'b000, if_al.led_ind}, 7'b000_0000);

        // Release: first edge loads A.
        step(4'hA, 1'b1);
        check("rel.seg_al", if_al.seg, 7'b000_1000);
        check("rel.led", {3'b000, if_al.led_ind}, 7'b000_1010);

        // Full sweep, one value per clock.
        for (int i = 0; i < 16; i++) begin
            step(4'(i), 1'b1);
            check_all($sformatf("sweep%0d", i), 4'(i), 1'b1);
        end

        // Spot literals from the sweep table.
        step(4'h0, 1'b1);
        check("lit0.seg_al", if_al.seg, 7'b100_0000);
        step(4'hF, 1'b1);
        check("litF.seg_al", if_al.seg, 7'b000_1110);

        // Input change between edges must not reach the pins early.
        step(4'h3, 1'b1);
        check("stab.pre", if_al.seg, 7'b011_0000);
        @(negedge clk);
        if_al.bin = 4'h8;
        if_ah.bin = 4'h8;
        #2;
        check("stab.mid_al", if_al.seg, 7'b011_0000);
        check("stab.mid_ah", if_ah.seg, 7'b100_1111);
        @(posedge clk);
        #1;
        check("stab.post_al", if_al.seg, 7'b000_0000);
        check("stab.post_led", {3'b000, if_al.led_ind}, 7'b000_1000);

        // Reset pulse mid-stream at value 7.
        step(4'h5, 1'b1);
        check_all("mid.5", 4'h5, 1'b1);
        step(4'h6, 1'b1);
        check_all("mid.6", 4'h6, 1'b1);
        step(4'h7, 1'b0);
        check("mid.rst_seg", if_al.seg, 7'b111_1111);
        check("mid.rst_led", {3'b000, if_al.led_ind}, 7'b000_0000);
        step(4'h7, 1'b1);
        check("mid.rel_seg", if_al.seg, 7'b111_1000);
        check("mid.rel_led", {3'b000, if_al.led_ind}, 7'b000_0111);

        // Active-high instance on value 2.
        step(4'h2, 1'b1);
        check("pol.seg_ah2", if_ah.seg, 7'b101_1011);

        // Randomized values with occasional reset edges.
        for (int i = 0; i < 80; i++) begin
            v = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 9) != 0);
            step(v, r);
            check_all($sformatf("rnd%0d", i), v, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bin_to_seven_segment.md
Name: bin_to_seven_segment

Overview:
- Registered 4-bit binary to hexadecimal seven-segment decoder with a binary LED mirror.
- Sits between a 4-bit value source (switches or a counter) and board-level LED and seven-segment pins.
- Displays 0-9 and A, b, C, d, E, F. Outputs are registered so the pins are glitch-free.

Parameters:
- SEG_ACTIVE_LOW, default 1, output polarity of seg.
  - 1: a lit segment drives 0.
  - 0: a lit segment drives 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- bin  input  4  binary value to display; unsigned 0..15.
- led_ind  output  4  registered copy of bin for discrete LEDs, active-high (bit n drives LED n).
- seg  output  7  registered segment drive: seg[0]=a, seg[1]=b, seg[2]=c, seg[3]=d, seg[4]=e, seg[5]=f, seg[6]=g. Polarity is set by SEG_ACTIVE_LOW.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). rst_n is sampled only on the rising edge of clk, and there is no asynchronous path.
- Reset (rst_n=0 at a rising edge):
  - led_ind becomes 4'b0000.
  - seg becomes all segments dark: 7'b1111111 when SEG_ACTIVE_LOW=1, 7'b0000000 when 0.
  - Reset has priority over bin.
- Normal operation: on each rising edge with rst_n=1, led_ind <= bin and seg <= decode(bin).
  - Latency is exactly 1 clock. There is no handshake; a new value is accepted every cycle.
- Output stability: outputs change only on clock edges. Changes on bin between edges have no effect.
- decode(bin), active-high patterns written g..a (bit6..bit0):
  - 0: 0111111
  - 1: 0000110
  - 2: 1011011
  - 3: 1001111
  - 4: 1100110
  - 5: 1101101
  - 6: 1111101
  - 7: 0000111
  - 8: 1111111
  - 9: 1101111
  - A: 1110111
  - b: 1111100
  - C: 0111001
  - d: 1011110
  - E: 1111001
  - F: 1110001
- Polarity: with SEG_ACTIVE_LOW=1 the registered seg value is the bitwise inverse of the table above.
- Full coverage: all 16 codes are defined. There is no blank or invalid code, so no default-to-X.
- Reset mid-operation: the next edge with rst_n=0 blanks seg and clears led_ind regardless of bin. The first edge after rst_n returns to 1 loads the current bin.
- No X propagation: the outputs are deterministic from the first reset edge. Before the first reset edge they are undefined, and the bench must not check them.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with bin=4'hA -> led_ind=0000, seg=1111111 (default polarity). Release rst_n; one edge later -> led_ind=1010, seg=0001000.
- Full sweep: drive bin=0..15, one value per clock, and check one edge later (active-low). Required seg values:
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000
  - 4→0011001, 5→0010010, 6→0000010, 7→1111000
  - 8→0000000, 9→0010000, A→0001000, b→0000011
  - C→1000110, d→0100001, E→0000110, F→0001110
  - In every case led_ind equals bin.
- Latency/stability: change bin 3→8 midway between edges -> seg stays 0110000 until the next rising edge, then becomes 0000000.
- Reset mid-stream: while sweeping, assert rst_n=0 for one edge at bin=7 -> that edge gives seg=1111111 and led_ind=0000. The next edge with rst_n=1 gives seg=1111000 and led_ind=0111.
- Polarity parameter: instantiate with SEG_ACTIVE_LOW=0 and bin=4'h2 -> seg=1011011 one edge later. During reset -> seg=0000000.
